// File: rtl/weight_scratchpad_loader.sv
// Weight scratchpad loader: fetches one weight column and presents it as a vector.
// Define SCRATCHPAD_AUTO_NEXT_EN to stream the remaining columns after each handshake.
module weight_scratchpad_loader #(
    parameter int WEIGHT_WIDTH = 5,
    parameter int WEIGHT_ROWS  = 96,
    parameter int WEIGHT_COLS  = 3,
    parameter int ADDR_WIDTH   = 9,
    parameter int COL_WIDTH    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [COL_WIDTH-1:0]    col_sel,
    output logic                    mem_read_en,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [WEIGHT_WIDTH-1:0] mem_data_in,
    output logic [WEIGHT_WIDTH-1:0] scratchpad_out [0:WEIGHT_ROWS-1],
    output logic                    scratchpad_valid,
    input  logic                    scratchpad_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    col_err
);

    localparam int ROW_W = $clog2(WEIGHT_ROWS + 1);
    localparam int SUM_W = ADDR_WIDTH + COL_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        PRESENT
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic [ROW_W-1:0]     row;
    logic [COL_WIDTH-1:0] col;
    logic                 tag_vld;
    logic [ROW_W-1:0]     tag_row;
    logic                 sel_ok;
    logic                 load_go;
    logic                 last_row;
    logic                 hs;
    logic [SUM_W-1:0]     addr_sum;

    assign sel_ok   = 32'(col_sel) < WEIGHT_COLS;
    assign load_go  = (state == IDLE) && start && sel_ok;
    assign last_row = row == ROW_W'(WEIGHT_ROWS - 1);
    assign hs       = (state == PRESENT) && scratchpad_ready;

`ifdef SCRATCHPAD_AUTO_NEXT_EN
    logic last_col;
    assign last_col = 32'(col) == (WEIGHT_COLS - 1);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (load_go) begin
                    state_nx = FETCH;
                end
            end
            FETCH: begin
                if (last_row) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                state_nx = PRESENT;
            end
            PRESENT: begin
                if (hs) begin
`ifdef SCRATCHPAD_AUTO_NEXT_EN
                    state_nx = last_col ? IDLE : FETCH;
`else
                    state_nx = IDLE;
`endif
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Base offset is formed wide before truncating to the memory address.
    assign addr_sum = SUM_W'(col) * SUM_W'(WEIGHT_ROWS) + SUM_W'(row);

    always_comb begin
        mem_read_en      = (state == FETCH);
        mem_addr         = '0;
        if (mem_read_en) begin
            mem_addr = addr_sum[ADDR_WIDTH-1:0];
        end
        scratchpad_valid = (state == PRESENT);
        busy             = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row     <= '0;
            col     <= '0;
            tag_vld <= 1'b0;
            tag_row <= '0;
            done    <= 1'b0;
            col_err <= 1'b0;
            for (int i = 0; i < WEIGHT_ROWS; i++) begin
                scratchpad_out[i] <= '0;
            end
        end else begin
            col_err <= (state == IDLE) && start && !sel_ok;
`ifdef SCRATCHPAD_AUTO_NEXT_EN
            done    <= hs && last_col;
`else
            done    <= hs;
`endif
            if (load_go) begin
                col <= col_sel;
                row <= '0;
            end else if (state == FETCH) begin
                row <= row + 1'b1;
            end
`ifdef SCRATCHPAD_AUTO_NEXT_EN
            if (hs && !last_col) begin
                col <= col + 1'b1;
                row <= '0;
            end
`endif
            // Read data returns one cycle after issue; the tag remembers its row.
            tag_vld <= (state == FETCH);
            tag_row <= row;
            if (tag_vld) begin
                scratchpad_out[tag_row] <= mem_data_in;
            end
        end
    end

endmodule

// File: doc/weight_scratchpad_loader.md
Name: weight_scratchpad_loader

Overview:
Producer side of the weight scratchpad bus. On a start command it fetches one weight column (WEIGHT_ROWS entries) from weight memory through a fixed 1-cycle-latency read port and assembles it into a parallel scratchpad vector. It then presents the vector to the vector multiplier with a valid/ready handshake. It sits between weight SRAM and vector_multiplier's scratchpad_in.

Parameters:
WEIGHT_WIDTH, 5, bits per weight entry
WEIGHT_ROWS, 96, entries per weight column (vector length)
WEIGHT_COLS, 3, number of weight columns stored in memory
ADDR_WIDTH, 9, weight memory address width (must hold WEIGHT_ROWS*WEIGHT_COLS-1)
COL_WIDTH, 2, width of column select

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous active-high reset
start  input  1  load request, sampled only in IDLE
col_sel  input  COL_WIDTH  column to load, sampled with start
mem_read_en  output  1  memory read strobe
mem_addr  output  ADDR_WIDTH  memory read address
mem_data_in  input  WEIGHT_WIDTH  read data, valid exactly 1 cycle after mem_read_en
scratchpad_out  output  WEIGHT_WIDTH x [0:WEIGHT_ROWS-1]  assembled weight vector
scratchpad_valid  output  1  vector complete and held stable
scratchpad_ready  input  1  consumer accepts vector
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse on final handshake
col_err  output  1  one-cycle pulse when start is given with col_sel >= WEIGHT_COLS

Behaviour:
- Reset (synchronous, active-high): state=IDLE. Row counter, column register and all scratchpad_out entries are 0. mem_read_en, mem_addr, scratchpad_valid, busy, done and col_err are 0. Reset mid-operation aborts the load immediately and discards partial data; a late mem_data_in is ignored.
- States: IDLE, FETCH, DRAIN, PRESENT.
- IDLE:
  - If start and col_sel < WEIGHT_COLS: latch col_sel, clear the row counter, go to FETCH.
  - If start and col_sel >= WEIGHT_COLS: pulse col_err for 1 cycle and stay in IDLE.
  - Start is ignored in all other states.
- FETCH:
  - mem_read_en=1 every cycle, with mem_addr = col*WEIGHT_ROWS + row (truncated to ADDR_WIDTH). The row counter increments each cycle.
  - When the read for row WEIGHT_ROWS-1 is issued, go to DRAIN.
- Write-back (FETCH and DRAIN): mem_data_in is written to scratchpad_out[row-1] on the cycle after each issued read. This is a 1-deep pipelined capture using a registered issue-row tag.
- DRAIN: mem_read_en=0. Capture the last entry, then go to PRESENT. Fetch latency from start to scratchpad_valid is WEIGHT_ROWS+2 cycles (98 at defaults).
- PRESENT:
  - scratchpad_valid=1 and scratchpad_out held constant.
  - valid must not drop before the handshake (valid && ready on the same edge).
  - On the handshake: done pulses the next cycle, valid deasserts and the state returns to IDLE.
  - If ready is held high on entry, the handshake occurs on the first PRESENT cycle.
- scratchpad_out keeps its last contents in IDLE until it is overwritten by the next load. It is only guaranteed meaningful while valid=1.
- busy = (state != IDLE).
- Address arithmetic is unsigned. col*WEIGHT_ROWS is computed at ADDR_WIDTH+COL_WIDTH bits before truncation.

Optional Feature:
Macro: SCRATCHPAD_AUTO_NEXT_EN.
- Defined: on the PRESENT handshake, if col < WEIGHT_COLS-1 the block increments col and re-enters FETCH directly, with busy held high and no start needed. done pulses only after the handshake of column WEIGHT_COLS-1; the block then returns to IDLE. A start with col_sel=k streams columns k..WEIGHT_COLS-1.
- Not defined: exactly one column per start, as described in Behaviour.

Test Plan:
- Reset then start with col_sel=0, mem[a]=a%32, ready=1 -> addresses 0..95 on 96 consecutive cycles, valid at cycle 98, scratchpad_out[i]=i%32, done pulses once, busy falls.
- start with col_sel=2, ready=0 for 10 cycles after valid -> mem_addr 192..287; valid and data held stable for all 10 cycles; handshake on the first ready=1; done 1 cycle later.
- start with col_sel=3 -> col_err pulses 1 cycle, mem_read_en stays 0, busy stays 0, state remains IDLE.
- Assert reset at FETCH row 40 -> next cycle busy=0, mem_read_en=0, scratchpad_out all 0. A new start with col_sel=1 then completes normally (addresses 96..191).
- start pulsed again during FETCH and PRESENT with col_sel=0 -> ignored; only one load and one done.
- With SCRATCHPAD_AUTO_NEXT_EN defined, start col_sel=0, ready=1 -> three back-to-back loads (addresses 0..287), three handshakes, a single done after the third, busy continuous.
